// File: rtl/pio_proto_pkg.sv
// Shared definitions for the two-command PIO sample protocol.
// Used by the ARM-side reader and the FPGA-side responder model.
package pio_proto_pkg;

    localparam logic [31:0] CMD_HI   = 32'h6;
    localparam logic [31:0] CMD_LO   = 32'h3;
    localparam logic [31:0] CMD_IDLE = 32'h0;

    localparam logic [15:0] TAG_HI = 16'h0045;
    localparam logic [15:0] TAG_LO = 16'h0048;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_PUSH
    } pio_state_t;

    typedef logic [31:0] sample_t;

endpackage

// File: rtl/pio_sync_fifo.sv
// First-word fall-through FIFO for assembled samples.
// Pops on empty and pushes on full are ignored.
module pio_sync_fifo
    import pio_proto_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  sample_t                  wr_data,
    input  logic                     rd_en,
    output sample_t                  rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [AW:0]     cnt;
    logic            do_wr;
    logic            do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign level   = cnt;
    assign rd_data = mem[rp];

    // storage array, written only on an accepted push
    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wp] <= wr_data;
        end
    end

    // pointers wrap naturally; occupancy only moves on a lone push or pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_wr) begin
                wp <= wp + 1'b1;
            end
            if (do_rd) begin
                rp <= rp + 1'b1;
            end
            if (do_wr && !do_rd) begin
                cnt <= cnt + 1'b1;
            end else if (do_rd && !do_wr) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/pio_sample_reader.sv
// Requests sample halves over the PIO command/reply pair and
// queues each assembled 32-bit sample for a downstream consumer.
module pio_sample_reader
    import pio_proto_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] CMD_HI   = pio_proto_pkg::CMD_HI,
    parameter logic [31:0] CMD_LO   = pio_proto_pkg::CMD_LO,
    parameter logic [31:0] CMD_IDLE = pio_proto_pkg::CMD_IDLE,
    parameter logic [15:0] TAG_HI   = pio_proto_pkg::TAG_HI,
    parameter logic [15:0] TAG_LO   = pio_proto_pkg::TAG_LO
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [31:0]              inputPio,
    output logic [31:0]              outputPio,
    input  logic                     rd_en,
    output logic [31:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    pio_state_t     state;
    pio_state_t     state_nx;
    logic [31:0]    cmd_nx;
    logic [15:0]    hi_q;
    logic [15:0]    hi_nx;
    logic [15:0]    lo_q;
    logic [15:0]    lo_nx;
    logic [TW-1:0]  timer;
    logic [TW-1:0]  timer_nx;
    logic           err_nx;
    logic           push;
    logic [15:0]    tag;
    logic           expired;

    assign tag     = inputPio[31:16];
    assign expired = (timer == TW'(TIMEOUT));

    // next-state, next command and capture decisions
    always_comb begin
        state_nx = state;
        cmd_nx   = outputPio;
        hi_nx    = hi_q;
        lo_nx    = lo_q;
        timer_nx = timer;
        err_nx   = timeout_err;
        push     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_nx = CMD_IDLE;
                if (enable && !full) begin
                    state_nx = ST_REQ_HI;
                    cmd_nx   = CMD_HI;
                    timer_nx = '0;
                end
            end
            ST_REQ_HI: begin
                if (tag == TAG_HI) begin
                    hi_nx    = inputPio[15:0];
                    state_nx = ST_REQ_LO;
                    cmd_nx   = CMD_LO;
                    timer_nx = '0;
                end else if (expired) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                    cmd_nx   = CMD_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_REQ_LO: begin
                if (tag == TAG_LO) begin
                    lo_nx    = inputPio[15:0];
                    state_nx = ST_PUSH;
                    cmd_nx   = CMD_IDLE;
                    timer_nx = '0;
                end else if (expired) begin
                    err_nx   = 1'b1;
                    state_nx = ST_IDLE;
                    cmd_nx   = CMD_IDLE;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_PUSH: begin
                push     = 1'b1;
                state_nx = ST_IDLE;
                cmd_nx   = CMD_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
                cmd_nx   = CMD_IDLE;
            end
        endcase
    end

    // FSM, command output, half-word and timer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            outputPio   <= CMD_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            outputPio   <= cmd_nx;
            hi_q        <= hi_nx;
            lo_q        <= lo_nx;
            timer       <= timer_nx;
            timeout_err <= err_nx;
        end
    end

    pio_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_data ({hi_q, lo_q}),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level)
    );

endmodule

// File: tb/tb_pio_sample_reader.sv
// Bench for pio_sample_reader: slow-polling responder model with random
// samples, a queue of expected words, and directed protocol corner cases.
module tb_pio_sample_reader;
    import pio_proto_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 255;
    localparam int POLL    = 40;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    enable;
    logic                    rd_en;
    logic [31:0]             inputPio;
    logic [31:0]             outputPio;
    logic [31:0]             rd_data;
    logic                    empty;
    logic                    full;
    logic                    timeout_err;
    logic [$clog2(DEPTH):0]  level;

    int          total = 0;
    int          bad = 0;
    logic        silent = 1'b0;
    logic [31:0] exp_q[$];
    logic        pend;
    logic [31:0] cur;
    int          hi_cnt = 0;
    int          lo_cnt = 0;

    always #5 clock = ~clock;

    pio_sample_reader #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .inputPio    (inputPio),
        .outputPio   (outputPio),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // FPGA-side responder: answers only on its poll tick
    initial begin : responder
        int   tick;
        logic want_lo;
        logic want_idle;
        logic want_hold;
        tick = 0;
        want_lo = 1'b0;
        want_idle = 1'b0;
        want_hold = 1'b0;
        inputPio = '0;
        pend = 1'b0;
        cur = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                inputPio = '0;
                tick = 0;
                pend = 1'b0;
                want_lo = 1'b0;
                want_idle = 1'b0;
                want_hold = 1'b0;
            end else begin
                if (want_lo) chk("switch_to_lo", outputPio, CMD_LO);
                if (want_idle) chk("switch_to_idle", outputPio, CMD_IDLE);
                if (want_hold) chk("stale_lo_ignored", outputPio, CMD_HI);
                want_lo = 1'b0;
                want_idle = 1'b0;
                tick = (tick == POLL - 1) ? 0 : tick + 1;
                if (tick == 0 && !silent) begin
                    if (outputPio == CMD_HI) begin
                        cur = $urandom;
                        inputPio = {TAG_HI, cur[31:16]};
                        pend = 1'b1;
                        want_lo = 1'b1;
                        hi_cnt++;
                    end else if (outputPio == CMD_LO) begin
                        inputPio = {TAG_LO, cur[15:0]};
                        if (pend) exp_q.push_back(cur);
                        pend = 1'b0;
                        want_idle = 1'b1;
                        lo_cnt++;
                    end
                end
                want_hold = !silent && outputPio == CMD_HI
                            && inputPio[31:16] == TAG_LO;
            end
        end
    end

    task automatic pop_chk(input string tag);
        logic [31:0] e;
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk(tag, rd_data, e);
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < DEPTH + 2 && !empty; i++) pop_chk(tag);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_model_empty", exp_q.size(), 32'd0);
    endtask

    task automatic wait_cmd(input logic [31:0] c, input int lim,
                            input string tag);
        int n;
        n = 0;
        while (outputPio !== c && n < lim) begin
            @(negedge clock);
            n++;
        end
        chk(tag, outputPio, c);
    endtask

    task automatic wait_level(input int lv, input int lim,
                              input string tag);
        int n;
        n = 0;
        while (int'(level) != lv && n < lim) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(level), 32'(lv));
    endtask

    task automatic wait_evt(input int c0, input bit use_hi,
                            input string tag);
        int n;
        n = 0;
        while ((use_hi ? hi_cnt : lo_cnt) == c0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        chk(tag, {31'd0, n < 300}, 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          n;
        int          c0;
        logic [31:0] acc;
        logic [31:0] lv0;
        reset = 1'b1;
        enable = 1'b0;
        rd_en = 1'b0;
        @(negedge clock);
        chk("rst_cmd", outputPio, CMD_IDLE);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err", {31'd0, timeout_err}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // one complete transaction
        enable = 1'b1;
        wait_cmd(CMD_HI, 5, "basic_hi");
        wait_cmd(CMD_LO, 200, "basic_lo");
        enable = 1'b0;
        wait_cmd(CMD_IDLE, 200, "basic_idle");
        wait_level(1, 5, "basic_level");
        chk("basic_nonempty", {31'd0, empty}, 32'd0);
        pop_chk("basic_data");

        // continuous acquisition with random consumer pops
        enable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (!empty && $urandom_range(0, 7) == 0) pop_chk("rand_data");
        end
        enable = 1'b0;
        repeat (150) @(negedge clock);
        drain("rand_drain");

        // fill to full, then a single pop restarts acquisition
        enable = 1'b1;
        wait_level(DEPTH, 4000, "fill_level");
        chk("fill_full", {31'd0, full}, 32'd1);
        acc = '0;
        repeat (120) begin
            @(negedge clock);
            acc = acc | outputPio;
        end
        chk("full_no_request", acc, CMD_IDLE);
        chk("full_level_hold", 32'(level), 32'(DEPTH));
        pop_chk("full_pop");
        @(negedge clock);
        chk("full_restart", outputPio, CMD_HI);
        enable = 1'b0;
        repeat (150) @(negedge clock);
        drain("full_drain");

        // silent responder -> timeout, then immediate retry
        silent = 1'b1;
        enable = 1'b1;
        lv0 = 32'(level);
        wait_cmd(CMD_HI, 5, "to_start");
        n = 0;
        while (!timeout_err && n < TIMEOUT + 20) begin
            @(negedge clock);
            n++;
        end
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_latency", {31'd0, n >= TIMEOUT && n <= TIMEOUT + 2}, 32'd1);
        chk("to_cmd_idle", outputPio, CMD_IDLE);
        chk("to_level", 32'(level), lv0);
        @(negedge clock);
        chk("to_retry", outputPio, CMD_HI);
        silent = 1'b0;
        enable = 1'b0;
        wait_cmd(CMD_IDLE, 200, "to_recover");
        repeat (5) @(negedge clock);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);
        drain("to_drain");

        // push and pop on the same edge at level 3
        enable = 1'b1;
        wait_level(3, 600, "sim_fill3");
        wait_cmd(CMD_LO, 200, "sim_lo");
        enable = 1'b0;
        c0 = lo_cnt;
        wait_evt(c0, 1'b0, "sim_lo_reply");
        @(negedge clock);
        chk("sim_pre_level", 32'(level), 32'd3);
        pop_chk("sim_pop_data");
        chk("sim_post_level", 32'(level), 32'd3);
        drain("sim_drain");

        // reset while waiting for the low half
        enable = 1'b1;
        c0 = hi_cnt;
        wait_evt(c0, 1'b1, "rst_hi_reply");
        repeat (3) @(negedge clock);
        chk("rst_in_req_lo", outputPio, CMD_LO);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_cmd", outputPio, CMD_IDLE);
        chk("arst_empty", {31'd0, empty}, 32'd1);
        chk("arst_err", {31'd0, timeout_err}, 32'd0);
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_cmd(CMD_LO, 300, "rst_new_lo");
        enable = 1'b0;
        wait_level(1, 200, "rst_level");
        pop_chk("rst_fresh_pair");
        chk("rst_model_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
